// File: rtl/snake_pkg.sv
// Shared constants and stage payloads for the snake board renderer.
package snake_pkg;

  localparam int unsigned MAP_N = 16;
  localparam int unsigned IDX_W = $clog2(MAP_N);
  localparam int unsigned POS_W = 11;
  localparam int unsigned RGB_W = 24;

  localparam logic [RGB_W-1:0] COL_OUT   = 24'h202020;
  localparam logic [RGB_W-1:0] COL_EDGE  = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] COL_SNAKE = 24'h00FF00;
  localparam logic [RGB_W-1:0] COL_BG    = 24'h000000;
  localparam logic [RGB_W-1:0] COL_GO    = 24'h800000;

  typedef struct packed {
    logic             de;
    logic             hs;
    logic             vs;
    logic             in_board;
    logic             on_edge;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } stage1_t;

endpackage

// File: rtl/snake_cell_cnt.sv
// Pixel-to-cell tracker: restarts at START, steps a 0..CELL-1 sub-count and bumps the cell index on wrap.
module snake_cell_cnt
  import snake_pkg::*;
#(
  parameter int unsigned START = 0,
  parameter int unsigned CELL  = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [POS_W-1:0] pos,
  output logic [IDX_W-1:0] idx_c
);

  localparam int unsigned SUB_W = 6;

  logic [SUB_W-1:0] sub_q;
  logic [SUB_W-1:0] sub_c;
  logic [IDX_W-1:0] idx_q;
  logic             at_start_c;

  // The start position itself is cell 0, so the registers only ever hold the continuation.
  always_comb begin
    at_start_c = (pos == POS_W'(START));
    sub_c      = at_start_c ? '0 : sub_q;
    idx_c      = at_start_c ? '0 : idx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_q <= '0;
      idx_q <= '0;
    end else if (adv) begin
      if (sub_c == SUB_W'(CELL - 1)) begin
        sub_q <= '0;
        idx_q <= idx_c + IDX_W'(1);
      end else begin
        sub_q <= sub_c + SUB_W'(1);
        idx_q <= idx_c;
      end
    end
  end

endmodule

// File: rtl/snake_map_render.sv
// Renders the 16x16 snake map into RGB video; map updates are deferred to frame boundaries to avoid tearing.
module snake_map_render
  import snake_pkg::*;
#(
  parameter int unsigned X0         = 320,
  parameter int unsigned Y0         = 40,
  parameter int unsigned CELL       = 40,
  parameter int unsigned BLINK_LOG2 = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MAP_N*MAP_N-1:0]   map_rows,
  input  logic                     hdmi_tx_en,
  input  logic                     game_over_flag,
  input  logic                     vid_de,
  input  logic                     vid_hs,
  input  logic                     vid_vs,
  output logic                     out_de,
  output logic                     out_hs,
  output logic                     out_vs,
  output logic [RGB_W-1:0]         out_rgb,
  output logic                     map_commit
);

  localparam int unsigned BOARD = MAP_N * CELL;
  localparam int unsigned X1    = X0 + BOARD;
  localparam int unsigned Y1    = Y0 + BOARD;
  localparam int unsigned BLK_W = BLINK_LOG2 + 1;
  localparam logic [POS_W-1:0] POS_MAX = '1;

  logic [MAP_N*MAP_N-1:0] pend;
  logic [MAP_N*MAP_N-1:0] disp;
  logic                   pend_go;
  logic                   pend_valid;
  logic                   disp_go;
  logic [BLK_W-1:0]       blink;
  logic [POS_W-1:0]       x;
  logic [POS_W-1:0]       y;
  logic                   de_prev;
  logic                   vs_prev;
  logic                   vs_rise_c;
  logic                   de_fall_c;
  logic [IDX_W-1:0]       col_c;
  logic [IDX_W-1:0]       row_c;
  stage1_t                s1;
  stage1_t                s1_c;
  logic [RGB_W-1:0]       rgb_c;

  assign vs_rise_c = vid_vs & ~vs_prev;
  assign de_fall_c = de_prev & ~vid_de;

  // Pending/display double buffer; a same-cycle strobe lands in pend after disp took the old copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend       <= '0;
      disp       <= '0;
      pend_go    <= 1'b0;
      disp_go    <= 1'b0;
      pend_valid <= 1'b0;
      map_commit <= 1'b0;
    end else begin
      map_commit <= 1'b0;
      if (vs_rise_c && pend_valid) begin
        disp       <= pend;
        disp_go    <= pend_go;
        pend_valid <= 1'b0;
        map_commit <= 1'b1;
      end
      if (hdmi_tx_en) begin
        pend       <= map_rows;
        pend_go    <= game_over_flag;
        pend_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink <= '0;
    end else if (!disp_go) begin
      blink <= '0;
    end else if (vs_rise_c) begin
      blink <= blink + BLK_W'(1);
    end
  end

  // Raster position, saturating rather than wrapping on over-long lines/frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x       <= '0;
      y       <= '0;
      de_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      de_prev <= vid_de;
      vs_prev <= vid_vs;
      if (de_fall_c) begin
        x <= '0;
      end else if (vid_de && (x != POS_MAX)) begin
        x <= x + POS_W'(1);
      end
      if (vs_rise_c) begin
        y <= '0;
      end else if (de_fall_c && (y != POS_MAX)) begin
        y <= y + POS_W'(1);
      end
    end
  end

  snake_cell_cnt #(.START(X0), .CELL(CELL)) u_col (
    .clk   (clk),
    .rst   (rst),
    .adv   (vid_de),
    .pos   (x),
    .idx_c (col_c)
  );

  snake_cell_cnt #(.START(Y0), .CELL(CELL)) u_row (
    .clk   (clk),
    .rst   (rst),
    .adv   (de_fall_c),
    .pos   (y),
    .idx_c (row_c)
  );

  always_comb begin
    s1_c          = '0;
    s1_c.de       = vid_de;
    s1_c.hs       = vid_hs;
    s1_c.vs       = vid_vs;
    s1_c.in_board = (x >= POS_W'(X0)) && (x < POS_W'(X1)) &&
                    (y >= POS_W'(Y0)) && (y < POS_W'(Y1));
    s1_c.on_edge  = (x == POS_W'(X0)) || (x == POS_W'(X1 - 1)) ||
                    (y == POS_W'(Y0)) || (y == POS_W'(Y1 - 1));
    s1_c.row      = row_c;
    s1_c.col      = col_c;
  end

  // Colour priority: outside, edge ring, occupied cell, background (red while blinking game-over).
  always_comb begin
    rgb_c = COL_BG;
    if (!s1.de) begin
      rgb_c = '0;
    end else if (!s1.in_board) begin
      rgb_c = COL_OUT;
    end else if (s1.on_edge) begin
      rgb_c = COL_EDGE;
    end else if (disp[{s1.row, s1.col}]) begin
      rgb_c = COL_SNAKE;
    end else if (disp_go && blink[BLK_W-1]) begin
      rgb_c = COL_GO;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= '0;
      out_de  <= 1'b0;
      out_hs  <= 1'b0;
      out_vs  <= 1'b0;
      out_rgb <= '0;
    end else begin
      s1      <= s1_c;
      out_de  <= s1.de;
      out_hs  <= s1.hs;
      out_vs  <= s1.vs;
      out_rgb <= rgb_c;
    end
  end

endmodule

// File: doc/snake_map_render.md
# snake_map_render

Pixel renderer for the 16x16 greedy-snake board, at the consuming end of the map interface driven by the DPB reader. It captures the 16 row bitmaps on each `hdmi_tx_en` strobe into a pending buffer and commits them to a display buffer at the next frame boundary, so a frame never tears. It then converts incoming video timing (DE/HS/VS) into 24-bit RGB for the HDMI transmitter, with a fixed 2-cycle pipeline.

## Interface
Parameters:
- `X0`, 320: first active pixel column of the board.
- `Y0`, 40: first active line of the board.
- `CELL`, 40: cell edge in pixels; range 2..63; board is 16*CELL square.
- `BLINK_LOG2`, 5: game-over blink half-period is 2^BLINK_LOG2 frames.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  asynchronous, active-low reset.
- `map_rows`  in  256  row r = bits [16r+15:16r]; bit c set = snake/food in column c.
- `hdmi_tx_en`  in  1  1-cycle strobe: `map_rows` valid this cycle.
- `game_over_flag`  in  1  level; sampled with `hdmi_tx_en`.
- `vid_de`, `vid_hs`, `vid_vs`  in  1 each  active-high timing from the timing generator.
- `out_de`, `out_hs`, `out_vs`  out  1 each  timing delayed 2 cycles.
- `out_rgb`  out  24  {R,G,B}, aligned with `out_de`.
- `map_commit`  out  1  1-cycle pulse when pending is copied to display.

## Operation
- Buffers:
  - `pend` (256 bits), `pend_go`, and `pend_valid`.
  - `disp` (256 bits) and `disp_go`.
- Capture: on `hdmi_tx_en`, `pend <= map_rows`, `pend_go <= game_over_flag`, `pend_valid <= 1`. A later strobe before commit overwrites `pend`; the last one wins.
- Commit: on a VS rising edge (`vid_vs` high and its previous registered value low) with `pend_valid`:
  - `disp <= pend`, `disp_go <= pend_go`.
  - `pend_valid <= 0`, `map_commit` pulses.
- Strobe and commit in the same cycle: `disp` takes the old `pend`; `pend` takes the new data; `pend_valid` stays 1.
- Position counters:
  - `x` counts DE cycles within a line and clears to 0 on DE falling.
  - `y` increments on DE falling and clears to 0 on VS rising.
  - Width: 11 bits each; saturate at 2047, no wrap.
- Cell tracking, no division:
  - `col`/`row` are 4-bit with sub-counters `sx`/`sy` in 0..CELL-1.
  - `sx`, `col` reset when `x == X0`; `sx` wraps at CELL-1 and then increments `col`.
  - `sy`, `row` behave the same against `y`/`Y0`, advancing once per line.
- In-board test: `X0 <= x < X0+16*CELL` and `Y0 <= y < Y0+16*CELL`.
- Colour priority:
  1. Outside board: 0x202020.
  2. Board edge, the outermost pixel ring: 0xFFFFFF.
  3. `disp[16*row+col]` set: 0x00FF00.
  4. Background: 0x000000. If `disp_go` and blink phase is 1, background is 0x800000 instead.
  - When `out_de` = 0, `out_rgb` = 0.
- Blink: a `BLINK_LOG2+1`-bit frame counter increments on every VS rising edge. Its MSB is the phase. The counter clears whenever `disp_go` = 0.

## Timing
- Latency is 2 cycles for every `vid_*` input to its `out_*` output:
  - Stage 1 registers timing, in-board/edge flags, and `col`/`row`.
  - Stage 2 registers the bitmap lookup and RGB mux.
- Reset state:
  - All outputs 0.
  - `pend`, `disp`, `pend_valid`, `pend_go`, `disp_go`, counters, and blink counter all 0.
  - The first frame after reset renders an empty board.
- Reset asserted mid-frame clears everything at once. Rendering resumes correctly only from the next VS rising edge; until then `x`/`y` restart from 0 at whatever point the stream is in.
- `map_commit` is asserted in the cycle after the VS rising edge is detected.
- `hdmi_tx_en` has no back-pressure: every strobe is accepted.

## Structure
- Shared package `snake_pkg`:
  - Colour constants `COL_OUT`, `COL_EDGE`, `COL_SNAKE`, `COL_BG`, `COL_GO`.
  - `MAP_N`=16.
- One natural sub-module, `snake_cell_cnt`: a pixel/cell sub-counter with start compare and CELL wrap. It is instantiated twice, for x/col and y/row.

## Test plan
- Reset then 1280x720 stimulus with no strobe: every in-board, non-edge pixel is 0x000000, the edge is 0xFFFFFF, outside is 0x202020, and `map_commit` never fires.
- Strobe with only row 0 bit 0 set: after the next VS rise `map_commit` pulses once. Pixels (321..359, 41..79) are 0x00FF00 and appear at `out_rgb` 2 cycles after the matching DE.
- Strobe A mid-frame, then strobe B before VS: the next frame shows B only.
- Strobe coincident with the VS rising edge: this frame shows the previous pending data, the next frame shows the new data, and `map_commit` fires on both frames.
- Map with `game_over_flag`=1, BLINK_LOG2=1: background alternates 0x000000/0x800000 every 2 frames. A subsequent map with flag 0 returns to black on its commit frame.
- Reset pulse mid-line: all outputs are 0 the next cycle and the display is empty. Correct geometry returns after the following VS.
